// File: rtl/seg7_decode_monitor.sv
// Receiver for a single-digit 7-segment driver: synchronizes the lines, waits for a stable
// pattern, decodes it back to hex and flags illegal glyphs and mod-16 sequence breaks.
module seg7_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_HIGH   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic       sel_in,
  output logic [3:0] hex_out,
  output logic       dp_out,
  output logic       valid,
  output logic       err_invalid,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  logic [8:0] sync1_q, sync2_q;
  logic [6:0] s_seg;
  logic       s_dp, s_sel;
  logic [7:0] pat;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] smp_q, smp_d;
  logic [7:0] held_pat_q, held_pat_d;
  logic       held_vld_q, held_vld_d;
  logic       accept;

  logic       is_glyph, is_blank;
  logic [3:0] glyph_hex;

  logic [3:0] hex_q, hex_d;
  logic       dp_q, dp_d;
  logic       valid_q, valid_d;
  logic       err_inv_q, err_inv_d;
  logic       seq_err_q, seq_err_d;
  logic       locked_q, locked_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sel_in, dp_in, seg_in};
      sync2_q <= sync1_q;
    end
  end

  assign s_seg = sync2_q[6:0] ^ {7{~ACTIVE_HIGH}};
  assign s_dp  = sync2_q[7] ^ ~ACTIVE_HIGH;
  assign s_sel = sync2_q[8];
  assign pat   = {s_dp, s_seg};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      smp_q      <= '0;
      held_pat_q <= '0;
      held_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      held_pat_q <= held_pat_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    smp_d      = smp_q;
    held_pat_d = held_pat_q;
    held_vld_d = held_vld_q;
    accept     = 1'b0;
    if (!s_sel) begin
      state_d    = StIdle;
      cnt_d      = '0;
      held_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSettle;
          cnt_d   = 8'd1;
          smp_d   = pat;
        end
        StSettle: begin
          if (pat != smp_q) begin
            smp_d = pat;
            cnt_d = 8'd1;
          end else if (cnt_inc == StableCnt) begin
            state_d    = StHeld;
            cnt_d      = cnt_inc;
            held_pat_d = smp_q;
            held_vld_d = 1'b1;
            // A short glitch that settles back onto the held pattern is not a new accept.
            accept     = !(held_vld_q && (smp_q == held_pat_q));
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (pat != smp_q) begin
            state_d = StSettle;
            smp_d   = pat;
            cnt_d   = 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    is_glyph  = 1'b1;
    is_blank  = 1'b0;
    glyph_hex = 4'h0;
    case (smp_q[6:0])
      7'h3F: glyph_hex = 4'h0;
      7'h06: glyph_hex = 4'h1;
      7'h5B: glyph_hex = 4'h2;
      7'h4F: glyph_hex = 4'h3;
      7'h66: glyph_hex = 4'h4;
      7'h6D: glyph_hex = 4'h5;
      7'h7D: glyph_hex = 4'h6;
      7'h07: glyph_hex = 4'h7;
      7'h7F: glyph_hex = 4'h8;
      7'h6F: glyph_hex = 4'h9;
      7'h77: glyph_hex = 4'hA;
      7'h7C: glyph_hex = 4'hB;
      7'h39: glyph_hex = 4'hC;
      7'h5E: glyph_hex = 4'hD;
      7'h79: glyph_hex = 4'hE;
      7'h71: glyph_hex = 4'hF;
      7'h00: begin
        is_glyph = 1'b0;
        is_blank = 1'b1;
      end
      default: is_glyph = 1'b0;
    endcase
  end

  // Output logic
  always_comb begin
    hex_d     = hex_q;
    dp_d      = dp_q;
    valid_d   = 1'b0;
    err_inv_d = 1'b0;
    seq_err_d = 1'b0;
    locked_d  = locked_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (is_glyph) begin
        hex_d     = glyph_hex;
        dp_d      = smp_q[7];
        valid_d   = 1'b1;
        seq_err_d = locked_q && (glyph_hex != hex_q + 4'd1);
        locked_d  = 1'b1;
      end else if (!is_blank) begin
        err_inv_d = 1'b1;
      end
    end
    if ((err_inv_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q     <= '0;
      dp_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_inv_q <= 1'b0;
      seq_err_q <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      err_inv_q <= err_inv_d;
      seq_err_q <= seq_err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dp_q;
  assign valid       = valid_q;
  assign err_invalid = err_inv_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Randomized bench for seg7_decode_monitor: an event-level reference model predicts every
// accept (kind, hex, dp, seq_err, cycle) and the output state after each phase.
module tb_seg7_decode_monitor;

  localparam int Lat = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, sel_a, sel_b;
  logic [3:0] hex_a, hex_b;
  logic       dpo_a, dpo_b, valid_a, valid_b, inv_a, inv_b, seq_a, seq_b, lock_a, lock_b;
  logic [7:0] cnt_a, cnt_b;

  seg7_decode_monitor #(.STABLE_CYCLES(4), .ACTIVE_HIGH(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .dp_in(dp_a), .sel_in(sel_a),
    .hex_out(hex_a), .dp_out(dpo_a), .valid(valid_a), .err_invalid(inv_a),
    .seq_err(seq_a), .locked(lock_a), .err_count(cnt_a)
  );

  seg7_decode_monitor #(.STABLE_CYCLES(4), .ACTIVE_HIGH(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .dp_in(dp_b), .sel_in(sel_b),
    .hex_out(hex_b), .dp_out(dpo_b), .valid(valid_b), .err_invalid(inv_b),
    .seq_err(seq_b), .locked(lock_b), .err_count(cnt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int kind;  // 1 = valid, 2 = err_invalid, 3 = stray seq_err
    int hex;
    int dp;
    int seq;
    int at;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  nev_b = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a)             got_q.push_back('{1, int'(hex_a), int'(dpo_a), int'(seq_a), cyc});
      if (inv_a)               got_q.push_back('{2, int'(hex_a), int'(dpo_a), int'(seq_a), cyc});
      if (seq_a && !valid_a)   got_q.push_back('{3, int'(hex_a), int'(dpo_a), 1, cyc});
      if (valid_b || inv_b)    nev_b++;
    end
  end

  // Reference model: glyph table plus the architectural state the outputs should show.
  int glyph [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                     'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
  int m_hex, m_dp, m_locked, m_err;
  int last_seg, last_dp;

  function automatic int decode(input int seg);
    for (int i = 0; i < 16; i++) if (glyph[i] == seg) return i;
    if (seg == 0) return 16;
    return 17;
  endfunction

  function automatic void model_reset();
    m_hex = 0; m_dp = 0; m_locked = 0; m_err = 0;
  endfunction

  function automatic void model_accept(input int seg, input int dp, input int at);
    int d;
    int sq;
    d = decode(seg);
    if (d < 16) begin
      sq = (m_locked != 0 && d != (m_hex + 1) % 16) ? 1 : 0;
      exp_q.push_back('{1, d, dp, sq, at});
      m_hex = d; m_dp = dp; m_locked = 1;
      if (sq != 0 && m_err < 255) m_err++;
    end else if (d == 17) begin
      exp_q.push_back('{2, m_hex, m_dp, 0, at});
      if (m_err < 255) m_err++;
    end
  endfunction

  // Called at a negedge: drive a pattern with sel high and hold it.
  task automatic apply(input int seg, input int dp, input int hold, input bit acc);
    sel_a = 1'b1;
    seg_a = 7'(seg);
    dp_a  = dp[0];
    if (acc) model_accept(seg, dp, cyc + Lat);
    last_seg = seg; last_dp = dp;
    repeat (hold) @(negedge clk);
  endtask

  task automatic compare_events(input string ph);
    int n;
    check({ph, " n_events"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d kind", ph, i), got_q[i].kind, exp_q[i].kind);
      check($sformatf("%s ev%0d hex", ph, i), got_q[i].hex, exp_q[i].hex);
      check($sformatf("%s ev%0d dp", ph, i), got_q[i].dp, exp_q[i].dp);
      check($sformatf("%s ev%0d seq_err", ph, i), got_q[i].seq, exp_q[i].seq);
      check($sformatf("%s ev%0d cycle", ph, i), got_q[i].at, exp_q[i].at);
    end
    got_q.delete();
    exp_q.delete();
    check({ph, " hex_out"}, hex_a, m_hex);
    check({ph, " dp_out"}, dpo_a, m_dp);
    check({ph, " locked"}, lock_a, m_locked);
    check({ph, " err_count"}, cnt_a, m_err);
  endtask

  task automatic wait_valid_b(input int start, input string tag, input int exp_hex);
    for (int i = 0; i < 20 && !valid_b; i++) @(negedge clk);
    check({tag, " latency"}, cyc - start, Lat);
    check({tag, " hex"}, hex_b, exp_hex);
    check({tag, " dp"}, dpo_b, 0);
    check({tag, " seq_err"}, seq_b, 0);
  endtask

  initial begin
    int seg, dp, r, hx, start, ev0;
    rst_n = 1'b0;
    seg_a = '0; dp_a = 1'b0; sel_a = 1'b0;
    seg_b = '0; dp_b = 1'b0; sel_b = 1'b0;
    model_reset();
    last_seg = -1; last_dp = -1;
    #2;
    check("reset hex_out", hex_a, 0);
    check("reset valid", valid_a, 0);
    check("reset err_invalid", inv_a, 0);
    check("reset seq_err", seq_a, 0);
    check("reset locked", lock_a, 0);
    check("reset err_count", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First accept, then a full count 0..F and the wrap back to 0.
    apply('h3F, 0, 20, 1'b1);
    compare_events("first");
    for (int i = 1; i < 17; i++) apply(glyph[i % 16], 0, 20, 1'b1);
    compare_events("count");

    // Skip, glitch, invalid, dp-only change, blank.
    apply('h06, 0, 20, 1'b1);
    apply('h5B, 0, 20, 1'b1);
    apply('h66, 0, 20, 1'b1);
    compare_events("skip");
    apply('h7F, 0, 20, 1'b1);
    apply('h00, 0, 3, 1'b0);
    apply('h7F, 0, 20, 1'b0);
    apply('h55, 0, 10, 1'b1);
    compare_events("glitch");
    apply('h6F, 0, 12, 1'b1);
    apply('h6F, 1, 12, 1'b1);
    apply('h00, 0, 12, 1'b1);
    apply('h77, 1, 12, 1'b1);
    compare_events("dp_blank");

    // Inverted-polarity instance, with a sel drop mid-settle.
    sel_b = 1'b1; seg_b = ~7'h06; dp_b = 1'b1;
    start = cyc;
    wait_valid_b(start, "inv first", 1);
    repeat (4) @(negedge clk);
    ev0 = nev_b;
    seg_b = ~7'h5B;
    repeat (2) @(negedge clk);
    sel_b = 1'b0;
    repeat (10) @(negedge clk);
    check("inv sel drop no event", nev_b, ev0);
    sel_b = 1'b1;
    start = cyc;
    wait_valid_b(start, "inv reselect", 2);

    // Randomized patterns against the model.
    for (int n = 0; n < 60; n++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          hx  = (r < 3) ? (m_hex + 1) % 16 : $urandom_range(0, 15);
          seg = glyph[hx];
        end else if (r < 8) begin
          do seg = $urandom_range(1, 127); while (decode(seg) != 17);
        end else begin
          seg = 0;
        end
        dp = $urandom_range(0, 1);
      end while (seg == last_seg && dp == last_dp);
      apply(seg, dp, $urandom_range(Lat + 2, Lat + 10), 1'b1);
    end
    compare_events("random");

    // Saturation of the error counter.
    r = (last_seg == 'h55 && last_dp == 0) ? 1 : 0;
    for (int i = 0; i < 300; i++) apply(((i + r) % 2 != 0) ? 'h56 : 'h55, 0, 8, 1'b1);
    compare_events("saturate");

    // Asynchronous reset in the middle of a settle.
    apply('h4F, 0, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async hex_out", hex_a, 0);
    check("async dp_out", dpo_a, 0);
    check("async valid", valid_a, 0);
    check("async locked", lock_a, 0);
    check("async err_count", cnt_a, 0);
    check("async inv hex_out", hex_b, 0);
    got_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Pattern still on the pins: it settles afresh with no pulse right after release.
    model_accept('h4F, 0, cyc + Lat);
    repeat (12) @(negedge clk);
    compare_events("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_decode_monitor.md
# seg7_decode_monitor

Self-checking receiver for the single-digit common-cathode 7-segment driver interface: samples the segment, decimal-point and digit-select lines, waits for a stable pattern, and decodes it back into a 4-bit hex value. It flags patterns that are not legal hex glyphs and breaks in the expected mod-16 count sequence. It sits in benches and on-chip self-test paths beside the driver, which is fed by the 2 Hz counter chain.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted (legal range 2..255).
- ACTIVE_HIGH, 1: 1 = common-cathode, so a lit segment reads 1. 0 = all seg_in and dp_in bits are inverted before decode.
- clk  in  1  system clock, 50 MHz nominal.
- rst_n  in  1  reset, asynchronous and active-low.
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}; bit 0 = a.
- dp_in  in  1  decimal-point line.
- sel_in  in  1  digit select; 1 = digit enabled.
- hex_out  out  4  last accepted hex value.
- dp_out  out  1  dp state captured with the last accepted pattern.
- valid  out  1  one-cycle pulse when a legal glyph is accepted.
- err_invalid  out  1  one-cycle pulse when a non-glyph, non-blank pattern is accepted.
- seq_err  out  1  one-cycle pulse, coincident with valid, when the value is not the previous value +1 mod 16.
- locked  out  1  set by the first valid; cleared only by reset.
- err_count  out  8  saturating count of err_invalid plus seq_err events; saturates at 255.

## Operation
- Synchronizer: 2-flop synchronizer on seg_in, dp_in and sel_in (9 bits). All logic after it uses the synchronized copies (s_seg, s_dp, s_sel).
- Polarity: when ACTIVE_HIGH=0, s_seg and s_dp are inverted before use.
- Glyph table ({g..a}, hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 = blank. Any other code is invalid. dp is ignored for glyph matching.
- FSM states:
  - IDLE: s_sel=0. Stability counter held at 0.
  - SETTLE: counting identical samples.
  - HELD: pattern accepted, waiting for a change.
- Transitions:
  - Any state → IDLE when s_sel=0.
  - IDLE → SETTLE when s_sel=1. The counter loads 1 and the sample register loads s_seg/s_dp.
  - SETTLE: if the sample equals the sample register, counter +1. Otherwise the sample register reloads and the counter goes to 1.
  - SETTLE → HELD when the counter reaches STABLE_CYCLES. On that transition exactly one accept event occurs.
  - HELD → SETTLE when s_seg or s_dp differs from the sample register; the register reloads and the counter goes to 1.
- Accept event:
  - Legal glyph: hex_out and dp_out update, valid=1. If locked=1 and value ≠ prev+1 mod 16 (F→0 is legal), seq_err=1. locked is then set.
  - Blank: no pulse, outputs held, no sequence check. The next valid is still compared against the last non-blank value.
  - Invalid: err_invalid=1; hex_out, dp_out and locked unchanged.
- err_count: increments by 1 per cycle in which err_invalid or seq_err is 1. Both cannot occur in the same cycle. It holds at 255.
- A pattern change of dp only re-triggers SETTLE. The same hex with a different dp re-accepts and raises seq_err if locked.

## Timing
- Reset values: hex_out=0, dp_out=0, valid=0, err_invalid=0, seq_err=0, locked=0, err_count=0, FSM=IDLE, synchronizers=0.
- Latency: input stable from sampling edge k (sel already high) → valid/err_invalid high in the cycle after edge k+1+STABLE_CYCLES. That is STABLE_CYCLES+2 clocks; 6 at the default.
- hex_out/dp_out change on the same edge that raises valid and are held until the next valid.
- Glitches shorter than STABLE_CYCLES synchronized cycles produce no event.
- sel dropping mid-SETTLE aborts with no event. sel dropping in HELD produces no event, and re-selecting the same pattern re-accepts it.
- Asynchronous reset mid-operation clears everything immediately. No pulse is emitted on the first clock after release.

## Test plan
- Reset then sel=1, seg=3F held → valid pulse exactly 6 clocks later, hex_out=0, locked=1, no seq_err, err_count=0.
- Step 3F,06,5B,…,71,3F, each held 20 clocks → 17 valid pulses with hex 0..F,0 and zero seq_err, including the F→0 wrap.
- seg=5B then 66, skipping 3 → valid with hex=4, seq_err=1, err_count=1.
- seg=7F with a 3-clock glitch to 00 → no event during the glitch, no re-accept. Then seg=55 held 10 clocks → err_invalid=1, hex_out unchanged, err_count +1.
- ACTIVE_HIGH=0 instance with seg=~06 → hex_out=1. Drop sel during SETTLE → no event. Re-raise sel → accept after 6 clocks.
- Force 300 invalid accepts → err_count=255 and holds. Assert rst_n=0 mid-SETTLE → all outputs 0 asynchronously.
